// File: rtl/led_chase_ctrl.sv
// led_chase_ctrl: 4-LED chase sequencer with run/pause/idle control.
// A prescaler derived from CLK_DIV and speed paces the pattern advances in RUN.
// While paused, single steps are taken on step_req.
// Optional build macro LED_ACTIVE_LOW_EN inverts the LED drive. Reset and IDLE
// then drive 1111.
module led_chase_ctrl #(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  input  logic       step_req,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [3:0] led_io,
  output logic [1:0] state_o,
  output logic       step_pulse,
  output logic       wrap
);

  localparam int CNT_W = DIV_W + 3;
  localparam logic [CNT_W-1:0] DIV_BASE = CNT_W'(CLK_DIV);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [3:0] LED_POL = 4'b1111;
`else
  localparam logic [3:0] LED_POL = 4'b0000;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_val;
  logic             term_hit;
  logic [3:0]       pat_q, pat_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       led_q, led_d;

  logic [3:0]       adv_pat;
  logic             adv_dir;
  logic             adv_wrap;

  // Start value of each pattern; only ring-right begins at the top LED.
  function automatic logic [3:0] start_of(input logic [1:0] m);
    return (m == 2'b01) ? 4'b1000 : 4'b0001;
  endfunction

  // The terminal value follows speed live, so a larger count is also terminal.
  assign term_val = (DIV_BASE << speed) - CNT_W'(1);
  assign term_hit = (cnt_q >= term_val);

  // Candidate next pattern for one advance; illegal values fall back to the start value.
  always_comb begin
    adv_pat = start_of(mode_q);
    adv_dir = 1'b0;
    case (mode_q)
      2'b00: begin
        case (pat_q)
          4'b0001: adv_pat = 4'b0010;
          4'b0010: adv_pat = 4'b0100;
          4'b0100: adv_pat = 4'b1000;
          default: adv_pat = 4'b0001;
        endcase
      end
      2'b01: begin
        case (pat_q)
          4'b1000: adv_pat = 4'b0100;
          4'b0100: adv_pat = 4'b0010;
          4'b0010: adv_pat = 4'b0001;
          default: adv_pat = 4'b1000;
        endcase
      end
      2'b10: begin
        // dir 0 walks up, dir 1 walks down. The direction flips on reaching an end,
        // so neither end value is ever shown twice in a row.
        if (!dir_q) begin
          case (pat_q)
            4'b0001: begin adv_pat = 4'b0010; adv_dir = 1'b0; end
            4'b0010: begin adv_pat = 4'b0100; adv_dir = 1'b0; end
            4'b0100: begin adv_pat = 4'b1000; adv_dir = 1'b1; end
            default: begin adv_pat = 4'b0001; adv_dir = 1'b0; end
          endcase
        end else begin
          case (pat_q)
            4'b1000: begin adv_pat = 4'b0100; adv_dir = 1'b1; end
            4'b0100: begin adv_pat = 4'b0010; adv_dir = 1'b1; end
            4'b0010: begin adv_pat = 4'b0001; adv_dir = 1'b0; end
            default: begin adv_pat = 4'b0001; adv_dir = 1'b0; end
          endcase
        end
      end
      default: begin
        case (pat_q)
          4'b0000, 4'b0001, 4'b0011, 4'b0111,
          4'b1111, 4'b1110, 4'b1100, 4'b1000: adv_pat = {pat_q[2:0], ~pat_q[3]};
          default:                            adv_pat = 4'b0001;
        endcase
      end
    endcase
    adv_wrap = (adv_pat == start_of(mode_q));
  end

  // Control FSM next-state logic, with priority clear > run > step_req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pat_d = 4'b0000;
        dir_d = 1'b0;
        if (!clear && run) begin
          state_d = RUN;
          mode_d  = mode;
          pat_d   = start_of(mode);
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          pat_d   = 4'b0000;
          dir_d   = 1'b0;
        end else begin
          if (term_hit) begin
            cnt_d  = '0;
            pat_d  = adv_pat;
            dir_d  = adv_dir;
            step_d = 1'b1;
            wrap_d = adv_wrap;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (!run) begin
            state_d = PAUSE;
            cnt_d   = '0;
          end
        end
      end
      PAUSE: begin
        cnt_d = '0;
        if (clear) begin
          state_d = IDLE;
          pat_d   = 4'b0000;
          dir_d   = 1'b0;
        end else if (run) begin
          state_d = RUN;
        end else if (step_req) begin
          pat_d  = adv_pat;
          dir_d  = adv_dir;
          step_d = 1'b1;
          wrap_d = adv_wrap;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pat_d   = 4'b0000;
        dir_d   = 1'b0;
      end
    endcase
    led_d = pat_d ^ LED_POL;
  end

  // State, prescaler, pattern and registered outputs, with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= 4'b0000;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      led_q   <= LED_POL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      led_q   <= led_d;
    end
  end

  assign led_io     = led_q;
  assign state_o    = state_q;
  assign step_pulse = step_q;
  assign wrap       = wrap_q;

endmodule
